// File: rtl/clint_responder.sv
// rtl/clint_responder.sv - core-local interruptor: mtime/mtimecmp/msip registers and machine interrupt lines
module clint_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [3:0]  data_out_mask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        ext_irq_async,
    output logic        machine_software_interrupt,
    output logic        machine_timer_interrupt,
    output logic        machine_external_interrupt
);
    localparam logic [2:0] OFF_MSIP    = 3'd0;
    localparam logic [2:0] OFF_CMP_LO  = 3'd1;
    localparam logic [2:0] OFF_CMP_HI  = 3'd2;
    localparam logic [2:0] OFF_TIME_LO = 3'd3;
    localparam logic [2:0] OFF_TIME_HI = 3'd4;
    localparam logic [2:0] OFF_CTRL    = 3'd5;
    localparam logic [7:0] PCNT_LAST   = 8'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [7:0]  pcnt;
    logic        msip;
    logic        timer_en;
    logic        mtip;
    logic        sync_meta;
    logic        sync_out;
    logic [2:0]  offset;
    logic [31:0] lane_mask;
    logic        wr_en;
    logic        wr_time_lo;
    logic        wr_time_hi;
    logic        tick;
    logic        unused_adr_bits;

    assign hit        = (data_adr[31:5] == BASE_ADDR[31:5]);
    assign offset     = data_adr[4:2];
    assign wr_en      = hit & mem_write;
    assign wr_time_lo = wr_en & (offset == OFF_TIME_LO);
    assign wr_time_hi = wr_en & (offset == OFF_TIME_HI);
    assign tick       = timer_en & (pcnt == PCNT_LAST);
    assign lane_mask  = {{8{data_out_mask[3]}}, {8{data_out_mask[2]}},
                         {8{data_out_mask[1]}}, {8{data_out_mask[0]}}};
    assign unused_adr_bits = ^data_adr[1:0];

    assign machine_software_interrupt = msip;
    assign machine_timer_interrupt    = mtip;
    assign machine_external_interrupt = sync_out;

    // Combinational so the single-cycle MEM stage never stalls; shows pre-write value on read+write.
    always_comb begin
        rdata = 32'h0;
        if (hit && mem_read) begin
            case (offset)
                OFF_MSIP:    rdata = {31'h0, msip};
                OFF_CMP_LO:  rdata = mtimecmp[31:0];
                OFF_CMP_HI:  rdata = mtimecmp[63:32];
                OFF_TIME_LO: rdata = mtime[31:0];
                OFF_TIME_HI: rdata = mtime[63:32];
                OFF_CTRL:    rdata = {31'h0, timer_en};
                default:     rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime     <= 64'h0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            pcnt      <= 8'h0;
            msip      <= 1'b0;
            timer_en  <= 1'b1;
            mtip      <= 1'b0;
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            mtip      <= (mtime >= mtimecmp);
            sync_meta <= ext_irq_async;
            sync_out  <= sync_meta;

            // A software write to either mtime half wins over the tick and restarts the prescaler.
            if (wr_time_lo || wr_time_hi) begin
                pcnt <= 8'h0;
                if (wr_time_lo) begin
                    mtime[31:0] <= (mtime[31:0] & ~lane_mask) | (wdata & lane_mask);
                end
                if (wr_time_hi) begin
                    mtime[63:32] <= (mtime[63:32] & ~lane_mask) | (wdata & lane_mask);
                end
            end else if (timer_en) begin
                if (tick) begin
                    pcnt  <= 8'h0;
                    mtime <= mtime + 64'd1;
                end else begin
                    pcnt <= pcnt + 8'd1;
                end
            end

            if (wr_en) begin
                case (offset)
                    OFF_MSIP: begin
                        if (data_out_mask[0]) msip <= wdata[0];
                    end
                    OFF_CMP_LO: mtimecmp[31:0]  <= (mtimecmp[31:0] & ~lane_mask) | (wdata & lane_mask);
                    OFF_CMP_HI: mtimecmp[63:32] <= (mtimecmp[63:32] & ~lane_mask) | (wdata & lane_mask);
                    OFF_CTRL: begin
                        if (data_out_mask[0]) timer_en <= wdata[0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clint_responder.sv
// tb/tb_clint_responder.sv - scoreboard bench for clint_responder with PRESCALE=1 and PRESCALE=4 instances
module tb_clint_responder;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        ext;
    logic [31:0] rdata0, rdata1;
    logic        hit0, hit1;
    logic        msi0, msi1, mti0, mti1, mei0, mei1;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    logic [63:0] m_mt[2];
    logic [63:0] m_cmp[2];
    bit          m_msip[2];
    bit          m_en[2];
    bit          m_mtip[2];
    int          m_pc[2];
    int          presc[2] = '{1, 4};
    bit          s1, s2;
    bit          exp_hit;

    clint_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .data_adr(data_adr), .data_out_mask(mask), .wdata(wdata),
        .rdata(rdata0), .hit(hit0), .ext_irq_async(ext),
        .machine_software_interrupt(msi0), .machine_timer_interrupt(mti0),
        .machine_external_interrupt(mei0));

    clint_responder #(.BASE_ADDR(BASE), .PRESCALE(4)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .data_adr(data_adr), .data_out_mask(mask), .wdata(wdata),
        .rdata(rdata1), .hit(hit1), .ext_irq_async(ext),
        .machine_software_interrupt(msi1), .machine_timer_interrupt(mti1),
        .machine_external_interrupt(mei1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input int i, input int off);
        case (off)
            0: return {31'h0, m_msip[i]};
            1: return m_cmp[i][31:0];
            2: return m_cmp[i][63:32];
            3: return m_mt[i][31:0];
            4: return m_mt[i][63:32];
            5: return {31'h0, m_en[i]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mt[i]   = 64'h0;
            m_cmp[i]  = '1;
            m_msip[i] = 1'b0;
            m_en[i]   = 1'b1;
            m_mtip[i] = 1'b0;
            m_pc[i]   = 0;
        end
        s1 = 1'b0;
        s2 = 1'b0;
    endtask

    task automatic model_step();
        bit w;
        int off;
        w   = mem_write && in_win(data_adr);
        off = int'(data_adr[4:2]);
        for (int i = 0; i < 2; i++) begin
            m_mtip[i] = (m_mt[i] >= m_cmp[i]);
            if (w && (off == 3 || off == 4)) begin
                if (off == 3) m_mt[i][31:0]  = merge(m_mt[i][31:0], wdata, mask);
                else          m_mt[i][63:32] = merge(m_mt[i][63:32], wdata, mask);
                m_pc[i] = 0;
            end else if (m_en[i]) begin
                m_pc[i]++;
                if (m_pc[i] == presc[i]) begin
                    m_pc[i] = 0;
                    m_mt[i] = m_mt[i] + 64'd1;
                end
            end
            if (w) begin
                if (off == 0 && mask[0]) m_msip[i] = wdata[0];
                if (off == 1) m_cmp[i][31:0]  = merge(m_cmp[i][31:0], wdata, mask);
                if (off == 2) m_cmp[i][63:32] = merge(m_cmp[i][63:32], wdata, mask);
                if (off == 5 && mask[0]) m_en[i] = wdata[0];
            end
        end
        s2 = s1;
        s1 = ext;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Monitor: pops the scoreboard whenever a load lands in the window.
    initial begin
        forever begin
            @(negedge clk);
            exp_hit = in_win(data_adr);
            chk("hit0", hit0, exp_hit);
            chk("hit1", hit1, exp_hit);
            if (mem_read && exp_hit) begin
                if (q0.size() == 0 || q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=empty required=entry t=%0t", $time);
                end else begin
                    chk("rdata0", rdata0, q0.pop_front());
                    chk("rdata1", rdata1, q1.pop_front());
                end
            end else begin
                chk("rdata0_idle", rdata0, 0);
                chk("rdata1_idle", rdata1, 0);
            end
            chk("mtip0", mti0, m_mtip[0]);
            chk("mtip1", mti1, m_mtip[1]);
            chk("msip0", msi0, m_msip[0]);
            chk("msip1", msi1, m_msip[1]);
            chk("meip0", mei0, s2);
            chk("meip1", mei1, s2);
        end
    end

    task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input logic [31:0] e0, input logic [31:0] e1,
                      input bit x0, input bit x1);
        mem_read  = rd;
        mem_write = wr;
        data_adr  = a;
        mask      = m;
        wdata     = d;
        if (rd && in_win(a)) begin
            q0.push_back(x0 ? e0 : model_read(0, int'(a[4:2])));
            q1.push_back(x1 ? e1 : model_read(1, int'(a[4:2])));
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] m);
        op(1'b0, 1'b1, BASE + 32'(off * 4), m, d, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rdx(input int off, input logic [31:0] e0, input logic [31:0] e1);
        op(1'b1, 1'b0, BASE + 32'(off * 4), 4'h0, 32'h0, e0, e1, 1'b1, 1'b1);
    endtask

    task automatic rdx0(input int off, input logic [31:0] e0);
        op(1'b1, 1'b0, BASE + 32'(off * 4), 4'h0, 32'h0, e0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int off;
        logic [31:0] a;
        logic [31:0] d;
        bit rd;
        bit wrb;

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        data_adr = 32'h0; mask = 4'h0; wdata = 32'h0; ext = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Free-running mtime after reset and reset register values
        idle(10);
        rdx(3, 32'd10, 32'd2);
        rdx(4, 32'd0, 32'd0);
        rdx(5, 32'd1, 32'd1);
        rdx(0, 32'd0, 32'd0);
        rdx(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rdx(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rdx(6, 32'd0, 32'd0);
        rdx(7, 32'd0, 32'd0);

        // Low-to-high carry, then full 64-bit wrap
        wr(4, 32'h0, 4'hF);
        wr(3, 32'hFFFF_FFFF, 4'hF);
        rdx0(3, 32'hFFFF_FFFF);
        rdx0(4, 32'd1);
        rdx0(3, 32'd1);
        wr(4, 32'hFFFF_FFFF, 4'hF);
        wr(3, 32'hFFFF_FFFF, 4'hF);
        rdx0(3, 32'hFFFF_FFFF);
        rdx0(4, 32'd0);
        rdx0(3, 32'd1);

        // Timer compare: rises one cycle after mtime reaches 20, falls one cycle after cmp is raised
        wr(4, 32'h0, 4'hF);
        wr(3, 32'h0, 4'hF);
        wr(2, 32'h0, 4'hF);
        wr(1, 32'd20, 4'hF);
        idle(18);
        chk("t3_mtip_before", mti0, 0);
        rdx0(3, 32'd20);
        chk("t3_mtip_rise", mti0, 1);
        wr(2, 32'd1, 4'hF);
        chk("t3_mtip_lag", mti0, 1);
        idle(1);
        chk("t3_mtip_fall", mti0, 0);

        // Software interrupt with byte-lane masking
        wr(0, 32'd1, 4'b0001);
        chk("t4_msip_set0", msi0, 1);
        chk("t4_msip_set1", msi1, 1);
        wr(0, 32'd0, 4'b0000);
        chk("t4_msip_hold", msi0, 1);
        wr(0, 32'd0, 4'b0001);
        chk("t4_msip_clr0", msi0, 0);
        chk("t4_msip_clr1", msi1, 0);
        wr(2, 32'h00AB_CD00, 4'b0110);
        rdx(2, 32'h00AB_CD01, 32'h00AB_CD01);

        // Enable gating and prescaler restart on mtime write
        wr(4, 32'h0, 4'hF);
        wr(3, 32'd50, 4'hF);
        wr(5, 32'd0, 4'b0001);
        rdx(3, 32'd51, 32'd50);
        idle(20);
        rdx(3, 32'd51, 32'd50);
        wr(5, 32'd1, 4'b0001);
        idle(2);
        wr(3, 32'd100, 4'hF);
        rdx(3, 32'd100, 32'd100);
        rdx(3, 32'd101, 32'd100);
        rdx(3, 32'd102, 32'd100);
        rdx(3, 32'd103, 32'd100);
        rdx(3, 32'd104, 32'd101);

        // External interrupt synchronizer latency
        #2 ext = 1'b1;
        @(posedge clk); #1;
        chk("t6_meip_1clk", mei0, 0);
        @(posedge clk); #1;
        chk("t6_meip_2clk0", mei0, 1);
        chk("t6_meip_2clk1", mei1, 1);

        // Asynchronous reset mid-operation with all interrupts active
        wr(0, 32'd1, 4'b0001);
        wr(1, 32'h0, 4'hF);
        wr(2, 32'h0, 4'hF);
        idle(1);
        chk("t6_pre_mtip", mti0, 1);
        chk("t6_pre_msip", msi1, 1);
        chk("t6_pre_meip", mei0, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_irqs0", {msi0, mti0, mei0}, 0);
        chk("t6_rst_irqs1", {msi1, mti1, mei1}, 0);
        @(posedge clk); #1;
        rdx(3, 32'd0, 32'd0);
        rdx(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rdx(5, 32'd1, 32'd1);
        wr(0, 32'd1, 4'hF);
        rst = 1'b1;
        rdx(0, 32'd0, 32'd0);
        op(1'b1, 1'b1, BASE + 32'd32, 4'hF, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        op(1'b0, 1'b1, BASE + 32'd36, 4'hF, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        op(1'b1, 1'b1, BASE - 32'd28, 4'hF, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        rdx(0, 32'd0, 32'd0);
        rdx(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            off = $urandom_range(0, 7);
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'd32 + 32'(off * 4);
                1:       a = $urandom & 32'hFFFF_FFFC;
                default: a = BASE + 32'(off * 4);
            endcase
            d   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
            rd  = $urandom_range(0, 1) == 1;
            wrb = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 15) == 0) ext = ~ext;
            op(rd, wrb, a, 4'($urandom_range(0, 15)), d, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        idle(2);
        chk("sb_drain", 64'(q0.size() + q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clint_responder.md
Name: clint_responder

Overview:
- Memory-mapped core-local interruptor. It is the responder on the core's data bus and the source of the three machine interrupt lines the datapath's trap logic consumes.
- Holds a 64-bit mtime counter, a 64-bit mtimecmp register and the msip bit.
- Synchronizes an asynchronous external interrupt request into the core clock domain.
- Sits at SoC top next to data memory; top-level muxes its read data onto the core's data_in when hit=1.

Parameters:
- BASE_ADDR, 32'h0200_0000, window base; must be 32-byte aligned.
- PRESCALE, 1, core clocks per mtime increment; legal range 1..255.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- mem_read  in  1  load strobe from core MEM stage
- mem_write  in  1  store strobe from core MEM stage
- data_adr  in  32  word-aligned address (bits[1:0] are 0)
- data_out_mask  in  4  byte-lane write enables; bit n enables byte n
- wdata  in  32  store data (the core's data_out)
- rdata  out  32  load data (mux into the core's data_in)
- hit  out  1  data_adr lies inside the 32-byte window
- ext_irq_async  in  1  asynchronous external interrupt request, level
- machine_software_interrupt  out  1  msip
- machine_timer_interrupt  out  1  mtip
- machine_external_interrupt  out  1  synchronized ext_irq_async

Behaviour:
- Decode:
  - hit = (data_adr[31:5] == BASE_ADDR[31:5]), combinational.
  - offset = data_adr[4:2].
- Register map (word offset):
  - 0: MSIP, bit0 only, other bits read 0.
  - 1: MTIMECMP_LO.
  - 2: MTIMECMP_HI.
  - 3: MTIME_LO.
  - 4: MTIME_HI.
  - 5: CTRL, bit0 = timer enable, other bits read 0.
  - 6, 7: reserved; read 0, writes ignored.
- Read path:
  - rdata = selected register when hit & mem_read, else 32'h0.
  - Combinational, same cycle, so the core's single-cycle MEM stage needs no stall.
  - data_out_mask is ignored on reads.
- Write path:
  - On a rising clk with hit & mem_write, each byte lane whose mask bit is 1 is updated from wdata; other lanes hold.
  - New value is visible to reads from the next cycle.
  - mem_read and mem_write both high: write performed; rdata shows the pre-write value.
- Prescaler:
  - 8-bit counter pcnt.
  - When CTRL.en=1: pcnt increments each cycle. When pcnt == PRESCALE-1, pcnt returns to 0 and mtime increments by 1 in that same cycle.
  - With PRESCALE=1, mtime increments every cycle.
  - When CTRL.en=0: pcnt and mtime hold.
- mtime:
  - 64-bit, wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
  - The carry from the low to the high word is internal to the same cycle.
- mtime write priority:
  - A write to MTIME_LO or MTIME_HI in a cycle suppresses that cycle's increment for the whole 64-bit value; the unwritten half holds.
  - The same write clears pcnt to 0.
- Timer interrupt:
  - mtip register <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on current register values.
  - Output lags a mtime or mtimecmp change by exactly one cycle.
  - Level output; cleared only by raising mtimecmp or lowering mtime.
- Software interrupt:
  - machine_software_interrupt = MSIP.bit0, registered.
  - Asserts the cycle after the write.
- External interrupt:
  - Two-flop synchronizer on ext_irq_async; machine_external_interrupt is the second flop.
  - Latency 2 clocks from a stable input; no edge latching (level semantics).
- Reset (rst=0, asynchronous, takes effect immediately, including mid-operation):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF (no spurious timer interrupt).
  - MSIP=0, CTRL.en=1, pcnt=0, both synchronizer flops=0.
  - All three interrupt outputs=0.
  - rdata/hit stay combinational from inputs and reset register values.
  - Bus strobes present during reset are ignored.
- Accesses with hit=0 have no effect; rdata=0.

Test Plan:
1. Reset then idle, PRESCALE=1 -> after 10 cycles read offset 3 returns 32'd10 (±pipeline alignment checked exactly); offset 4 returns 0; all interrupts 0.
2. mtime = 32'hFFFF_FFFF in LO via write, HI=0; let one increment -> LO=0, HI=1 the next cycle; separately preload both halves to all-ones -> wraps to 0.
3. Write MTIMECMP_HI=0, then MTIMECMP_LO=20, with mtime counting from 0 -> machine_timer_interrupt rises exactly one cycle after mtime reaches 20. Then write MTIMECMP_HI=1 -> falls the cycle after.
4. Write MSIP=1 with mask 4'b0001 -> machine_software_interrupt=1 next cycle. Write 0 with mask 4'b0000 -> stays 1. Write 0 with mask 4'b0001 -> clears.
5. PRESCALE=4, CTRL.en=1 -> mtime increments every 4th clock. Write CTRL=0 -> mtime frozen for 20 cycles. Mid-count mtime write -> pcnt restarts, next increment 4 clocks later.
6. Drive ext_irq_async high asynchronously -> output high after 2 clocks. Assert rst=0 mid-count with mtip=1 -> all outputs 0 immediately and registers at reset values; address outside window with mem_write -> no register change, hit=0, rdata=0.
